// File: rtl/mm_out_pack.sv
// Requantises the mm accumulator stream to D_W bits and packs 32/D_W elements per
// 32-bit AXI-stream beat, regenerating tlast per M*M frame and flagging misplaced tlast.
module mm_out_pack #(
  parameter int unsigned D_W     = 8,
  parameter int unsigned D_W_ACC = 16,
  parameter int unsigned M       = 8,
  parameter int unsigned SHIFT   = 4,
  parameter int unsigned SIGNED  = 1
) (
  input  logic               mm_clk,
  input  logic               mm_rst,
  input  logic               s_axis_tvalid,
  input  logic [D_W_ACC-1:0] s_axis_tdata,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  output logic               m_axis_tvalid,
  output logic [31:0]        m_axis_tdata,
  output logic [3:0]         m_axis_tkeep,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
  output logic               frame_err
);

  localparam int unsigned PACK  = 32 / D_W;
  localparam int unsigned NELEM = M * M;
  localparam int unsigned LW    = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned EW    = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam int unsigned AW    = D_W_ACC + 1;

  localparam logic signed [AW-1:0] RND  = AW'((64'd1 << SHIFT) >> 1);
  localparam logic signed [AW-1:0] SMAX = AW'((64'd1 << (D_W - 1)) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  localparam logic        [AW-1:0] UMAX = AW'((64'd1 << D_W) - 1);

  logic [LW-1:0] lane_q;
  logic [EW-1:0] elem_q;
  logic [31:0]   pack_q;
  logic          out_valid_q;
  logic [31:0]   out_data_q;
  logic [3:0]    out_keep_q;
  logic          out_last_q;
  logic          frame_err_q;

  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] shd;
  logic        [AW-1:0] ush;
  logic [D_W-1:0]       q;

  logic        accept;
  logic        lane_last;
  logic        elem_last;
  logic        close;
  logic        word_last;
  logic [31:0] word;
  logic [3:0]  keep;

  assign s_axis_tready = ~out_valid_q | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign lane_last     = (lane_q == LW'(PACK - 1));
  assign elem_last     = (elem_q == EW'(NELEM - 1));
  assign word_last     = elem_last | s_axis_tlast;
  assign close         = lane_last | word_last;

  // One extra bit of headroom so the rounding add cannot wrap.
  always_comb begin
    if (SIGNED != 0) begin
      ext = $signed({s_axis_tdata[D_W_ACC-1], s_axis_tdata});
    end else begin
      ext = $signed({1'b0, s_axis_tdata});
    end
    sum = ext + RND;
    shd = sum >>> SHIFT;
    ush = $unsigned(sum) >> SHIFT;
    if (SIGNED != 0) begin
      if (shd > SMAX) begin
        q = SMAX[D_W-1:0];
      end else if (shd < SMIN) begin
        q = SMIN[D_W-1:0];
      end else begin
        q = shd[D_W-1:0];
      end
    end else begin
      if (ush > UMAX) begin
        q = '1;
      end else begin
        q = ush[D_W-1:0];
      end
    end
  end

  // Lanes above the current one are already zero because pack_q clears on close.
  always_comb begin
    word = pack_q;
    for (int k = 0; k < PACK; k++) begin
      if (LW'(k) == lane_q) begin
        word[k*D_W +: D_W] = q;
      end
    end
    for (int b = 0; b < 4; b++) begin
      keep[b] = ((b * 8) < ((int'(lane_q) + 1) * D_W));
    end
  end

  always_ff @(posedge mm_clk or posedge mm_rst) begin
    if (mm_rst) begin
      lane_q      <= '0;
      elem_q      <= '0;
      pack_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (accept) begin
        if (close) begin
          pack_q <= '0;
          lane_q <= '0;
        end else begin
          pack_q <= word;
          lane_q <= lane_q + LW'(1);
        end
        if (word_last) begin
          elem_q <= '0;
        end else begin
          elem_q <= elem_q + EW'(1);
        end
        if (s_axis_tlast != elem_last) begin
          frame_err_q <= 1'b1;
        end
      end
      if (accept && close) begin
        out_valid_q <= 1'b1;
        out_data_q  <= word;
        out_keep_q  <= keep;
        out_last_q  <= word_last;
      end else if (m_axis_tready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_mm_out_pack.sv
// Scoreboard bench for mm_out_pack: stimulus pushes expected words, a monitor pops and
// compares every output handshake.
module tb_mm_out_pack;

  logic        mm_clk = 1'b0;
  logic        mm_rst;
  logic        s_axis_tvalid;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        frame_err;

  always #5 mm_clk = ~mm_clk;

  mm_out_pack #(
    .D_W    (8),
    .D_W_ACC(16),
    .M      (8),
    .SHIFT  (4),
    .SIGNED (1)
  ) dut (
    .mm_clk       (mm_clk),
    .mm_rst       (mm_rst),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .frame_err    (frame_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_beats = 0;
  int    stall_cnt = 0;

  int          m_lane = 0;
  int          m_elem = 0;
  logic [31:0] m_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] rq(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    v = (v + 8) >>> 4;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  function automatic logic [15:0] ramp(input int i);
    return 16'(i * 613 - 20000);
  endfunction

  task automatic model_elem(input logic [15:0] d, input logic l);
    beat_t b;
    m_word[m_lane*8 +: 8] = rq(d);
    m_lane++;
    m_elem++;
    if (m_lane == 4 || m_elem == 64 || l) begin
      b.data = m_word;
      b.keep = 4'((1 << m_lane) - 1);
      b.last = (m_elem == 64) || l;
      exp_q.push_back(b);
      if (b.last) m_elem = 0;
      m_lane = 0;
      m_word = '0;
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send(input logic [15:0] d, input logic l);
    int   waits;
    logic acc;
    waits = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    forever begin
      #1;
      acc = s_axis_tready;
      @(posedge mm_clk);
      if (acc) break;
      waits++;
      stall_cnt++;
      if (waits > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got no s_axis_tready, expected acceptance within 200 cycles");
        break;
      end
      @(negedge mm_clk);
    end
    @(negedge mm_clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_ramp(input int first);
    for (int i = first; i < 64; i++) begin
      model_elem(ramp(i), i == 63);
      send(ramp(i), i == 63);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(negedge mm_clk);
      n++;
    end
    @(negedge mm_clk);
    @(negedge mm_clk);
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  logic  stall_prev = 1'b0;
  beat_t prev_beat;

  always @(negedge mm_clk) begin
    beat_t e;
    #2;
    if (!mm_rst) begin
      check("s_tready_rule", 64'(s_axis_tready), 64'(!m_axis_tvalid || m_axis_tready));
      if (stall_prev) begin
        check("hold_stable", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast},
              {1'b1, prev_beat});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%08h, expected no word", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 64'(m_axis_tdata), 64'(e.data));
          check("word_keep", 64'(m_axis_tkeep), 64'(e.keep));
          check("word_last", 64'(m_axis_tlast), 64'(e.last));
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    end else begin
      stall_prev = 1'b0;
    end
  end

  int beats0;

  initial begin
    mm_rst        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge mm_clk);
    check("reset_outputs", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, frame_err},
          '0);
    mm_rst = 1'b0;
    @(negedge mm_clk);

    // Rounding and saturation words open a frame that a ramp then completes.
    push_exp(32'hFF010201, 4'hF, 1'b0);
    send(16'h0010, 1'b0); send(16'h0018, 1'b0); send(16'h0008, 1'b0); send(16'hFFF0, 1'b0);
    push_exp(32'h807F807F, 4'hF, 1'b0);
    send(16'h7FFF, 1'b0); send(16'h8000, 1'b0); send(16'h0800, 1'b0); send(16'hF7F0, 1'b0);
    m_elem = 8;
    send_ramp(8);
    drain();
    check("frame_err_clean", 64'(frame_err), 64'd0);

    // Full frame at full rate: no stalls, 16 words.
    stall_cnt = 0;
    beats0 = n_beats;
    send_ramp(0);
    drain();
    check("no_stall", 64'(stall_cnt), 64'd0);
    check("beat_count", 64'(n_beats - beats0), 64'd16);
    check("frame_err_full", 64'(frame_err), 64'd0);

    // Backpressure mid-frame.
    stall_cnt = 0;
    beats0 = n_beats;
    fork
      send_ramp(0);
      begin
        repeat (20) @(negedge mm_clk);
        m_axis_tready = 1'b0;
        repeat (10) @(negedge mm_clk);
        m_axis_tready = 1'b1;
      end
    join
    drain();
    check("bp_tready_dropped", 64'(stall_cnt > 0), 64'd1);
    check("bp_beat_count", 64'(n_beats - beats0), 64'd16);

    // Early tlast on the 6th element.
    push_exp(32'h04030201, 4'hF, 1'b0);
    push_exp(32'h00000605, 4'h3, 1'b1);
    for (int i = 1; i <= 6; i++) send(16'(i * 16), i == 6);
    check("frame_err_early", 64'(frame_err), 64'd1);
    drain();
    send_ramp(0);
    drain();
    check("frame_err_sticky", 64'(frame_err), 64'd1);

    // Reset after a partial word.
    for (int i = 0; i < 3; i++) send(ramp(i), 1'b0);
    #3;
    mm_rst = 1'b1;
    #1;
    check("midreset_outputs",
          {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, frame_err}, '0);
    @(negedge mm_clk);
    mm_rst = 1'b0;
    @(negedge mm_clk);
    m_lane = 0;
    m_elem = 0;
    m_word = '0;
    beats0 = n_beats;
    send_ramp(0);
    drain();
    check("post_reset_beats", 64'(n_beats - beats0), 64'd16);
    check("frame_err_post_reset", 64'(frame_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
